// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a controller and the PS/2 host transmitter.
//
// Handshake: the master holds tx_data stable with tx_valid high; the byte is
// taken on the first rising clock edge where tx_valid & tx_ready are both high.
// tx_ready is high only while the transmitter is idle, so tx_valid asserted while
// busy has no effect. Each accepted byte ends in exactly one of tx_done or
// tx_error, each a single-cycle pulse. Neither pulse is produced if reset aborts
// the frame.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard.
// Drives the open-drain PS/2 clock/data pads through output enables
// (1 = pull low). The device clocks the frame. busy lets a neighbouring
// receiver ignore line activity that this block causes.
//
// Optional build macro PS2_TX_ACK_CHECK_EN: when defined, the data level at the
// 11th falling edge is checked, and a NACK (data high) ends in tx_error. When it
// is undefined, that level is ignored and a completed frame always ends in tx_done.
// Timeouts end in tx_error in both builds.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 250,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_WAIT    = 3'd3,
    ST_XFER    = 3'd4,
    ST_ACK     = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // One shared cycle counter. It is sized for the largest interval it must time.
  localparam int MAX_A   = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_B   = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST   = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;   // falling edges seen in this frame
  logic [9:0]       shreg_q,   shreg_d;     // {stop, parity, data}; bit 0 goes out next
  logic             clk_oe_q,  clk_oe_d;
  logic             dat_oe_q,  dat_oe_d;
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q,    busy_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_error_q, tx_error_d;
  // Pad synchronisers. They reset to 1, the idle line level, so that the
  // release of reset is not seen as a falling edge.
  logic             clk_s1_q,   clk_s1_d;
  logic             clk_s2_q,   clk_s2_d;
  logic             clk_prev_q, clk_prev_d;
  logic             dat_s1_q,   dat_s1_d;
  logic             dat_s2_q,   dat_s2_d;
`ifdef PS2_TX_ACK_CHECK_EN
  logic             nack_q,    nack_d;      // data level sampled at the 11th fall
`endif

  logic clk_fall;
  logic abort;

  assign clk_fall = clk_prev_q & ~clk_s2_q;

  // Next-state logic: frame sequencing, bit shifting and timeout handling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_ONE;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;
    tx_done_d  = 1'b0;
    tx_error_d = 1'b0;
    abort      = 1'b0;
    clk_s1_d   = ps2_clk_in;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_dat_in;
    dat_s2_d   = dat_s1_q;
`ifdef PS2_TX_ACK_CHECK_EN
    nack_d     = nack_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tx.tx_valid && tx_ready_q) begin
          shreg_d    = {1'b1, ~^tx.tx_data, tx.tx_data};
          bit_cnt_d  = '0;
          state_d    = ST_INHIBIT;
          clk_oe_d   = 1'b1;
          dat_oe_d   = 1'b0;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
          nack_d     = 1'b0;
`endif
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d  = ST_REQ;
          cnt_d    = '0;
          dat_oe_d = 1'b1;              // start bit, with the clock still held low
        end
      end

      ST_REQ: begin
        if (cnt_q == REQ_LAST) begin
          state_d  = ST_WAIT;
          cnt_d    = '0;
          clk_oe_d = 1'b0;              // hand the clock over to the device
        end
      end

      ST_WAIT: begin
        if (clk_fall) begin
          // This is the first falling edge. Data bit 0 goes out right away.
          state_d   = ST_XFER;
          cnt_d     = '0;
          bit_cnt_d = 4'd1;
          dat_oe_d  = ~shreg_q[0];
          shreg_d   = {1'b1, shreg_q[9:1]};
        end else if (cnt_q == START_LAST) begin
          abort = 1'b1;
        end
      end

      ST_XFER: begin
        // The counter keeps running into ACK, so the transfer timeout covers
        // the whole span from the first fall to the acknowledge.
        if (cnt_q == XFER_LAST) begin
          abort = 1'b1;
        end else if (clk_fall) begin
          if (bit_cnt_q == 4'd10) begin
            state_d = ST_ACK;
`ifdef PS2_TX_ACK_CHECK_EN
            nack_d  = dat_s2_q;
`endif
          end else begin
            // Falls 2..10 send data[1..7], then parity, then stop. Stop is a 1,
            // which shifts in from the top and releases the data line.
            bit_cnt_d = bit_cnt_q + 4'd1;
            dat_oe_d  = ~shreg_q[0];
            shreg_d   = {1'b1, shreg_q[9:1]};
          end
        end
      end

      ST_ACK: begin
        // Any further falls are ignored here. Wait for both lines to go idle.
        if (cnt_q == XFER_LAST) begin
          abort = 1'b1;
        end else if (clk_s2_q && dat_s2_q) begin
          state_d = ST_DONE;
`ifdef PS2_TX_ACK_CHECK_EN
          tx_done_d  = ~nack_q;
          tx_error_d = nack_q;
`else
          tx_done_d  = 1'b1;
`endif
        end
      end

      ST_DONE: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end

      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        clk_oe_d   = 1'b0;
        dat_oe_d   = 1'b0;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase

    // A timeout releases both lines and returns to IDLE in the same step.
    if (abort) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      clk_oe_d   = 1'b0;
      dat_oe_d   = 1'b0;
      tx_ready_d = 1'b1;
      busy_d     = 1'b0;
      tx_done_d  = 1'b0;
      tx_error_d = 1'b1;
    end
  end

  // State and output registers. Async reset releases the pads at once.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
      nack_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
`ifdef PS2_TX_ACK_CHECK_EN
      nack_q     <= nack_d;
`endif
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_dat_oe  = dat_oe_q;
  assign tx.tx_ready = tx_ready_q;
  assign tx.busy     = busy_q;
  assign tx.tx_done  = tx_done_q;
  assign tx.tx_error = tx_error_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model, behavioural PS/2 device,
// frame-level reference model with an expected-frame queue, and a summary report.
module tb_ps2_host_tx;

  localparam int INH = 60;
  localparam int REQ = 12;
  localparam int ST  = 400;
  localparam int XT  = 1500;
  localparam int HP  = 25;     // device half clock period in system cycles

`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic [2:0] dbg_state;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  ps2_host_tx_if tx_if ();

  // Wired-AND pads with pull-ups.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQ),
    .START_TIMEOUT  (ST),
    .XFER_TIMEOUT   (XT)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .tx         (tx_if),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Line frame as the device should see it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  // ---------------- monitor ----------------
  int cyc = 0;
  int t_clk_rise = 0, t_dat_rise = 0, t_clk_fall = 0, t_err = 0, t_first_fall = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0, start_cnt = 0;
  logic clk_oe_prev = 1'b0, dat_oe_prev = 1'b0, done_prev = 1'b0, err_prev = 1'b0;

  // Edge timestamps and pulse bookkeeping, sampled mid-cycle.
  always @(negedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (ps2_clk_oe && !clk_oe_prev) begin
      t_clk_rise <= cyc;
      start_cnt  <= start_cnt + 1;
    end
    if (ps2_dat_oe && !dat_oe_prev && ps2_clk_oe) t_dat_rise <= cyc;
    if (!ps2_clk_oe && clk_oe_prev) t_clk_fall <= cyc;
    if (tx_if.tx_done) done_cnt <= done_cnt + 1;
    if (tx_if.tx_error) begin
      err_cnt <= err_cnt + 1;
      t_err   <= cyc;
    end
    if (tx_if.tx_done && tx_if.tx_error) both_cnt <= both_cnt + 1;
    if ((tx_if.tx_done && done_prev) || (tx_if.tx_error && err_prev)) long_cnt <= long_cnt + 1;
    clk_oe_prev <= ps2_clk_oe;
    dat_oe_prev <= ps2_dat_oe;
    done_prev   <= tx_if.tx_done;
    err_prev    <= tx_if.tx_error;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit push);
    int guard;
    guard = 0;
    @(negedge CLOCK_50);
    while (!tx_if.tx_ready && guard < 5000) begin
      @(negedge CLOCK_50);
      guard++;
    end
    if (!tx_if.tx_ready) check("ready_wait", 0, 1);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_if.tx_valid = 1'b0;
    check("ready_drop", tx_if.tx_ready, 0);
    check("busy_rise", tx_if.busy, 1);
    if (push) exp_q.push_back(frame_of(b));
  endtask

  // Behavioural keyboard: it waits for request-to-send and then generates
  // n_edges clock pulses. It samples data on each rising edge. It ACKs when
  // asked on pulse 11.
  task automatic dev_frame(input int n_edges, input bit ack_low);
    logic [10:0] rx;
    int  guard;
    bit  seen_low;
    rx = '0;
    guard = 0;
    seen_low = 1'b0;
    while (guard < INH + REQ + 200) begin
      @(negedge CLOCK_50);
      guard++;
      if (!ps2_clk_in) seen_low = 1'b1;
      else if (seen_low && !ps2_dat_in) break;
    end
    if (!(seen_low && ps2_clk_in && !ps2_dat_in)) begin
      check("rts_seen", 0, 1);
      return;
    end
    rx[0] = ps2_dat_in;
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11 && ack_low) begin
        repeat (HP / 2) @(negedge CLOCK_50);
        dev_dat_low = 1'b1;
        repeat (HP - HP / 2) @(negedge CLOCK_50);
      end else begin
        repeat (HP) @(negedge CLOCK_50);
      end
      dev_clk_low = 1'b1;
      if (e == 1) t_first_fall = cyc;
      repeat (HP) @(negedge CLOCK_50);
      if (e <= 10) rx[e] = ps2_dat_in;
      dev_clk_low = 1'b0;
    end
    if (n_edges == 11) begin
      repeat (HP) @(negedge CLOCK_50);
      dev_dat_low = 1'b0;
      if (exp_q.size() > 0) check("frame", {21'd0, rx}, {21'd0, exp_q.pop_front()});
      else check("frame_queued", 0, 1);
    end
  endtask

  task automatic wait_outcome(input int d0, input int e0, input int limit);
    int g;
    g = 0;
    while (done_cnt == d0 && err_cnt == e0 && g < limit) begin
      @(negedge CLOCK_50);
      g++;
    end
    repeat (4) @(negedge CLOCK_50);
  endtask

  // One full frame, with the device either ACKing or NACKing.
  task automatic run_frame(input logic [7:0] b, input bit ack_low);
    int d0, e0, exp_done;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(b, 1'b1);
    dev_frame(11, ack_low);
    wait_outcome(d0, e0, 300);
    exp_done = (ack_low || !ACK_CHECK) ? 1 : 0;
    check("done_pulses", done_cnt - d0, exp_done);
    check("error_pulses", err_cnt - e0, 1 - exp_done);
    check("ready_back", tx_if.tx_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    logic       exp_bit;
    int d0, e0, s0, dt;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check("rst_ready", tx_if.tx_ready, 1);
    check("rst_busy", tx_if.busy, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    check("rst_done", tx_if.tx_done, 0);
    check("rst_error", tx_if.tx_error, 0);
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("idle_ready", tx_if.tx_ready, 1);

    // 0xED set-LEDs, device ACKs; inhibit and request timing
    run_frame(8'hED, 1'b1);
    check("inhibit_len", t_dat_rise - t_clk_rise, INH);
    check("req_len", t_clk_fall - t_dat_rise, REQ);
    check("idle_busy", tx_if.busy, 0);
    check("idle_oe", {ps2_clk_oe, ps2_dat_oe}, 0);

    // Parity extremes
    run_frame(8'h00, 1'b1);
    run_frame(8'h01, 1'b1);
    run_frame(8'hFF, 1'b1);

    // Random bytes, with mostly ACK and some NACK
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      run_frame(b, ($urandom_range(0, 3) != 0));
    end

    // Device never clocks: start timeout
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    wait_outcome(d0, e0, INH + REQ + ST + 100);
    check("st_error", err_cnt - e0, 1);
    check("st_no_done", done_cnt - d0, 0);
    check("st_latency", t_err - t_clk_fall, ST);
    check("st_oe", {ps2_clk_oe, ps2_dat_oe}, 0);

    // Device stops after 5 edges: transfer timeout, then a normal send
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    dev_frame(5, 1'b0);
    wait_outcome(d0, e0, XT + 200);
    check("xt_error", err_cnt - e0, 1);
    check("xt_no_done", done_cnt - d0, 0);
    dt = t_err - t_first_fall;
    check("xt_latency_window", (dt >= XT + 1 && dt <= XT + 5), 1);
    check("xt_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    run_frame(8'($urandom_range(0, 255)), 1'b1);

    // NACK at edge 11
    run_frame(8'hF4, 1'b0);

    // Reset at the 6th falling edge, with tx_valid held during the frame
    d0 = done_cnt;
    e0 = err_cnt;
    b = 8'($urandom_range(0, 255));
    @(negedge CLOCK_50);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    dev_frame(5, 1'b0);
    repeat (HP) @(negedge CLOCK_50);
    dev_clk_low = 1'b1;
    repeat (6) @(negedge CLOCK_50);
    exp_bit = ~b[5];
    check("edge6_data", ps2_dat_oe, exp_bit);
    reset = 1'b1;
    tx_if.tx_valid = 1'b0;
    #1;
    check("midrst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    check("midrst_ready", tx_if.tx_ready, 1);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    s0 = start_cnt;
    repeat (INH + REQ + 50) @(negedge CLOCK_50);
    check("midrst_no_resend", start_cnt - s0, 0);
    check("midrst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    // Pulse integrity over the whole run
    check("done_err_overlap", both_cnt, 0);
    check("pulse_width", long_cnt, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #(60000 * 20);
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
